// File: rtl/image_loader.sv
// ============================================================================
//  Module   : image_loader
//  Purpose  : Writer side of the layer1 image memory. Converts an 8-bit
//             unsigned pixel stream to signed 8-bit, writes one frame at
//             sequential addresses, then pulses load and waits for net_done.
//  Options  : define PIXEL_CENTER_EN for s_data-128 (MSB inversion) instead
//             of the default shift-right conversion.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module image_loader #(
    parameter int CHANNEL_SIZE = 783,
    parameter int ADDR_W       = 10,
    parameter int CNT_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    input  logic              s_sof,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              load,
    input  logic              net_done,
    output logic              busy,
    output logic              sof_err,
    output logic [CNT_W-1:0]  frame_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILL   = 3'd1,
        S_LAST   = 3'd2,
        S_LAUNCH = 3'd3,
        S_WAIT   = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(CHANNEL_SIZE);

    state_t             state_q,     state_d;
    logic [ADDR_W-1:0]  cnt_q,       cnt_d;
    logic               s_ready_q,   s_ready_d;
    logic               mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q,  mem_addr_d;
    logic [7:0]         mem_data_q,  mem_data_d;
    logic               load_q,      load_d;
    logic               busy_q,      busy_d;
    logic               sof_err_q,   sof_err_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic               w_accept;
    logic [7:0]         w_pixel;

    function automatic logic [7:0] convert(input logic [7:0] px);
`ifdef PIXEL_CENTER_EN
        return {~px[7], px[6:0]};
`else
        return {1'b0, px[7:1]};
`endif
    endfunction

    assign w_accept = s_valid && s_ready_q;
    assign w_pixel  = convert(s_data);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        busy_d      = busy_q;
        sof_err_d   = 1'b0;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    if (s_sof) begin
                        mem_we_d   = 1'b1;
                        mem_addr_d = '0;
                        mem_data_d = w_pixel;
                        cnt_d      = ADDR_W'(1);
                        busy_d     = 1'b1;
                        state_d    = S_FILL;
                    end else begin
                        sof_err_d  = 1'b1;
                    end
                end
            end
            S_FILL: begin
                if (w_accept) begin
                    mem_we_d   = 1'b1;
                    mem_data_d = w_pixel;
                    if (s_sof) begin
                        // Restart: earlier pixels get overwritten by the new frame
                        mem_addr_d = '0;
                        cnt_d      = ADDR_W'(1);
                        sof_err_d  = 1'b1;
                    end else begin
                        mem_addr_d = cnt_q;
                        cnt_d      = cnt_q + ADDR_W'(1);
                        if (cnt_q == c_LAST_ADDR) begin
                            state_d = S_LAST;
                        end
                    end
                end
            end
            S_LAST: begin
                state_d = S_LAUNCH;
            end
            S_LAUNCH: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (net_done) begin
                    state_d     = S_IDLE;
                    cnt_d       = '0;
                    busy_d      = 1'b0;
                    frame_cnt_d = frame_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Ready and load are registered off the next state so they align with it
    assign s_ready_d = (state_d == S_IDLE) || (state_d == S_FILL);
    assign load_d    = (state_d == S_LAUNCH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            s_ready_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            load_q      <= 1'b0;
            busy_q      <= 1'b0;
            sof_err_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            s_ready_q   <= s_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            load_q      <= load_d;
            busy_q      <= busy_d;
            sof_err_q   <= sof_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign s_ready   = s_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;
    assign load      = load_q;
    assign busy      = busy_q;
    assign sof_err   = sof_err_q;
    assign frame_cnt = frame_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_image_loader.sv
// ============================================================================
//  Module   : tb_image_loader
//  Purpose  : Scoreboard bench for image_loader; a small second instance
//             exercises the frame counter wrap.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_image_loader;

    localparam int CS = 783;
    localparam int AW = 10;
    localparam int CW = 8;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic [7:0]    s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_sof = 1'b0;
    logic          net_done = 1'b0;
    logic          s_ready, mem_we, load, busy, sof_err;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic [CW-1:0] frame_cnt;

    logic          r2 = 1'b1;
    logic [7:0]    d2 = '0;
    logic          v2 = 1'b0;
    logic          sof2 = 1'b0;
    logic          nd2 = 1'b0;
    logic          rdy2, we2, load2, busy2, err2;
    logic [1:0]    addr2;
    logic [7:0]    data2;
    logic [7:0]    fc2;

    image_loader #(.CHANNEL_SIZE(CS), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_sof(s_sof),
        .s_ready(s_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
        .load(load), .net_done(net_done), .busy(busy), .sof_err(sof_err),
        .frame_cnt(frame_cnt)
    );

    image_loader #(.CHANNEL_SIZE(3), .ADDR_W(2), .CNT_W(8)) dut_small (
        .clk(clk), .rst(r2), .s_data(d2), .s_valid(v2), .s_sof(sof2),
        .s_ready(rdy2), .mem_we(we2), .mem_addr(addr2), .mem_data(data2),
        .load(load2), .net_done(nd2), .busy(busy2), .sof_err(err2),
        .frame_cnt(fc2)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int addr;
        int data;
        int c;
    } wr_t;

    wr_t wq[$];
    int  lq[$];
    int  eq[$];
    wr_t mw;
    int  mc;

    // Model state: 0 idle, 1 filling, 2 waiting for net_done
    int m_st = 0;
    int m_cnt = 0;
    int m_frames = 0;

    task automatic chk(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic int exp_px(input int d);
`ifdef PIXEL_CENTER_EN
        return (d ^ 8'h80) & 8'hFF;
`else
        return (d & 8'hFF) >> 1;
`endif
    endfunction

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (wq.size() == 0) begin
                chk("unexpected_write", int'(mem_we), 0);
            end else begin
                mw = wq.pop_front();
                chk("wr_addr", int'(mem_addr), mw.addr);
                chk("wr_data", int'(mem_data), mw.data);
                chk("wr_cycle", cyc, mw.c);
            end
        end else if (wq.size() != 0 && wq[0].c <= cyc) begin
            mw = wq.pop_front();
            chk("missing_write", int'(mem_we), 1);
        end

        if (load === 1'b1) begin
            chk("load_excl_we", int'(mem_we), 0);
            if (lq.size() == 0) begin
                chk("unexpected_load", int'(load), 0);
            end else begin
                mc = lq.pop_front();
                chk("load_cycle", cyc, mc);
            end
        end else if (lq.size() != 0 && lq[0] <= cyc) begin
            mc = lq.pop_front();
            chk("missing_load", int'(load), 1);
        end

        if (sof_err === 1'b1) begin
            if (eq.size() == 0) begin
                chk("unexpected_sof_err", int'(sof_err), 0);
            end else begin
                mc = eq.pop_front();
                chk("sof_err_cycle", cyc, mc);
            end
        end else if (eq.size() != 0 && eq[0] <= cyc) begin
            mc = eq.pop_front();
            chk("missing_sof_err", int'(sof_err), 1);
        end
    end

    task automatic beat(input int d, input bit sof);
        int  n;
        wr_t w;
        n = 0;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = 8'(d);
        s_sof   = sof;
        while (!s_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            chk("ready_timeout", int'(s_ready), 1);
            s_valid = 1'b0;
            return;
        end
        w.data = exp_px(d);
        w.c    = cyc + 1;
        if (m_st == 2) begin
            chk("ready_in_wait", int'(s_ready), 0);
        end else if (m_st == 0) begin
            if (sof) begin
                w.addr = 0;
                wq.push_back(w);
                m_cnt = 1;
                m_st  = 1;
            end else begin
                eq.push_back(cyc + 1);
            end
        end else begin
            if (sof) begin
                w.addr = 0;
                wq.push_back(w);
                eq.push_back(cyc + 1);
                m_cnt = 1;
            end else begin
                w.addr = m_cnt;
                wq.push_back(w);
                if (m_cnt == CS) begin
                    lq.push_back(cyc + 2);
                    m_st = 2;
                end else begin
                    m_cnt++;
                end
            end
        end
    endtask

    task automatic idle_in();
        @(negedge clk);
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    task automatic done_pulse();
        @(negedge clk);
        s_valid  = 1'b0;
        net_done = 1'b1;
        if (m_st == 2) begin
            m_st  = 0;
            m_cnt = 0;
            m_frames++;
        end
        @(negedge clk);
        net_done = 1'b0;
    endtask

    task automatic small_frame();
        int n;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            v2   = 1'b1;
            d2   = 8'(j);
            sof2 = (j == 0);
            n    = 0;
            while (!rdy2 && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (!rdy2) chk("small_ready", int'(rdy2), 1);
        end
        @(negedge clk);
        v2 = 1'b0;
        n  = 0;
        while (!load2 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("small_load", int'(load2), 1);
        @(negedge clk);
        nd2 = 1'b1;
        @(negedge clk);
        nd2 = 1'b0;
    endtask

    initial begin
        // Reset held with s_valid asserted: nothing may move
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_sof   = 1'b1;
            s_data  = 8'h55;
            chk("rst_s_ready", int'(s_ready), 0);
            chk("rst_mem_we", int'(mem_we), 0);
            chk("rst_load", int'(load), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_sof_err", int'(sof_err), 0);
            chk("rst_mem_addr", int'(mem_addr), 0);
            chk("rst_mem_data", int'(mem_data), 0);
            chk("rst_frame_cnt", int'(frame_cnt), 0);
        end
        rst     = 1'b0;
        s_valid = 1'b0;
        chk("ready_first_cycle", int'(s_ready), 0);
        @(negedge clk);
        chk("ready_second_cycle", int'(s_ready), 1);

        // Full frame, data = i%256
        for (int i = 0; i <= CS; i++) beat(i % 256, i == 0);
        idle_in();
        repeat (3) @(negedge clk);
        chk("wait_s_ready", int'(s_ready), 0);
        chk("wait_busy", int'(busy), 1);

        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_sof   = 1'b0;
            chk("ready_held_low", int'(s_ready), 0);
        end
        done_pulse();
        chk("done_frame_cnt", int'(frame_cnt), 1);
        chk("done_busy", int'(busy), 0);
        chk("done_s_ready", int'(s_ready), 1);

        @(negedge clk);
        net_done = 1'b1;
        @(negedge clk);
        net_done = 1'b0;
        chk("idle_net_done_cnt", int'(frame_cnt), 1);

        // Framing errors in IDLE, then a frame restarted after 100 beats
        for (int i = 0; i < 5; i++) beat(i + 1, 1'b0);
        beat(8'h10, 1'b1);
        for (int i = 1; i < 100; i++) beat(i + 7, 1'b0);
        beat(8'h44, 1'b1);
        for (int i = 1; i <= CS; i++) beat((i * 3) % 256, 1'b0);
        idle_in();
        repeat (3) @(negedge clk);
        done_pulse();
        chk("restart_frame_cnt", int'(frame_cnt), 2);

        // Reset in the middle of a frame
        beat(8'hA0, 1'b1);
        for (int i = 1; i < 300; i++) beat(i, 1'b0);
        @(negedge clk);
        rst      = 1'b1;
        s_valid  = 1'b0;
        m_st     = 0;
        m_cnt    = 0;
        m_frames = 0;
        repeat (2) begin
            @(negedge clk);
            chk("midrst_mem_we", int'(mem_we), 0);
            chk("midrst_load", int'(load), 0);
            chk("midrst_busy", int'(busy), 0);
            chk("midrst_frame_cnt", int'(frame_cnt), 0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i <= CS; i++) beat(255 - (i % 256), i == 0);
        idle_in();
        repeat (3) @(negedge clk);
        chk("post_rst_busy", int'(busy), 1);
        done_pulse();
        chk("post_rst_frame_cnt", int'(frame_cnt), 1);

        // Frame counter wrap on a 4-pixel instance
        @(negedge clk);
        r2 = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 256; k++) begin
            small_frame();
            chk("wrap_frame_cnt", int'(fc2), (k + 1) % 256);
        end

        repeat (5) @(negedge clk);
        chk("pending_writes", wq.size(), 0);
        chk("pending_loads", lq.size(), 0);
        chk("pending_sof_err", eq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, %0d miscompares so far", miscompares);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
